dmem_arbiter: RTL and testbench

- Shares the single read port of the data-memory ROM between two requesters: the CPU load path and the video/display fetch engine.
- Decodes the memory-mapped switch address in front of the ROM and serves switch reads locally from a debounced switch register.
- Sits between the requesters and the data memory, replacing direct CPU-to-memory wiring.
- Returns read data with fixed 1-cycle latency through a per-requester valid handshake.

---
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/video read-port arbiter for the data ROM with debounced switch I/O
module dmem_arbiter #(
  parameter logic [31:0] IO_ADDR    = 32'd254,
  parameter int          DEB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        vid_req,
  input  logic [31:0] vid_addr,
  output logic        vid_gnt,
  output logic        vid_rvalid,
  output logic [31:0] vid_rdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        switch1,
  input  logic        switch2,
  input  logic        switch3
);

  // Counter value at which the next stable cycle would bring it to DEB_CYCLES-1;
  // stable is loaded on that edge instead of incrementing.
  localparam logic [15:0] DEB_LOAD = 16'(DEB_CYCLES - 2);

  typedef enum logic {
    LAST_CPU = 1'b0,
    LAST_VID = 1'b1
  } grant_t;

  grant_t      last_grant;
  grant_t      last_grant_nxt;
  logic [31:0] mem_addr_q;

  logic        cpu_pend;
  logic        vid_pend;
  logic        cpu_io;
  logic        vid_io;
  logic [7:0]  io_lat;
  logic [31:0] cpu_hold;
  logic [31:0] vid_hold;

  logic [2:0]  raw_sw;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  sync_prev;
  logic [2:0]  stable;
  logic [15:0] deb_cnt;
  logic [7:0]  io_pat;

  assign raw_sw = {switch1, switch2, switch3};
  assign io_pat = {stable[1:0], stable, stable};

  // Round-robin grant and ROM address mux; grants are suppressed while reset is held
  always_comb begin
    cpu_gnt        = 1'b0;
    vid_gnt        = 1'b0;
    last_grant_nxt = last_grant;
    mem_addr       = mem_addr_q;
    if (rst_n) begin
      if (cpu_req && (!vid_req || last_grant == LAST_VID)) begin
        cpu_gnt        = 1'b1;
        last_grant_nxt = LAST_CPU;
        mem_addr       = cpu_addr;
      end else if (vid_req) begin
        vid_gnt        = 1'b1;
        last_grant_nxt = LAST_VID;
        mem_addr       = vid_addr;
      end
    end
  end

  // Arbiter state: last winner and the address held on the ROM when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= LAST_VID;
      mem_addr_q <= 32'd0;
    end else begin
      last_grant <= last_grant_nxt;
      mem_addr_q <= mem_addr;
    end
  end

  // One-cycle return tracking; the switch pattern is captured with the grant so a
  // debounce update on the same edge does not leak into the read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_pend <= 1'b0;
      vid_pend <= 1'b0;
      cpu_io   <= 1'b0;
      vid_io   <= 1'b0;
      io_lat   <= 8'd0;
      cpu_hold <= 32'd0;
      vid_hold <= 32'd0;
    end else begin
      cpu_pend <= cpu_gnt;
      vid_pend <= vid_gnt;
      cpu_io   <= cpu_gnt && (cpu_addr == IO_ADDR);
      vid_io   <= vid_gnt && (vid_addr == IO_ADDR);
      if (cpu_gnt || vid_gnt) begin
        io_lat <= io_pat;
      end
      if (cpu_pend) begin
        cpu_hold <= cpu_rdata;
      end
      if (vid_pend) begin
        vid_hold <= vid_rdata;
      end
    end
  end

  // Return data: live ROM word or latched switch pattern while valid, else last value
  always_comb begin
    cpu_rvalid = cpu_pend;
    vid_rvalid = vid_pend;
    cpu_rdata  = cpu_hold;
    vid_rdata  = vid_hold;
    if (cpu_pend) begin
      cpu_rdata = cpu_io ? {24'd0, io_lat} : mem_rdata;
    end
    if (vid_pend) begin
      vid_rdata = vid_io ? {24'd0, io_lat} : mem_rdata;
    end
  end

  // Switch synchronizer and shared debounce counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 3'd0;
      sync2     <= 3'd0;
      sync_prev <= 3'd0;
      stable    <= 3'd0;
      deb_cnt   <= 16'd0;
    end else begin
      sync1     <= raw_sw;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (sync2 == stable || sync2 != sync_prev) begin
        deb_cnt <= 16'd0;
      end else if (deb_cnt == DEB_LOAD) begin
        stable  <= sync2;
        deb_cnt <= 16'd0;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam logic [31:0] IO_ADDR = 32'd254;
  localparam int          DEB     = 16;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        vid_req;
  logic [31:0] vid_addr;
  logic        vid_gnt;
  logic        vid_rvalid;
  logic [31:0] vid_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        switch1;
  logic        switch2;
  logic        switch3;

  dmem_arbiter #(.IO_ADDR(IO_ADDR), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .switch1(switch1), .switch2(switch2), .switch3(switch3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  logic [31:0] rom_q;
  always_ff @(posedge clk) rom_q <= mem_addr;
  assign mem_rdata = rom_word(rom_q);

  typedef struct {
    logic        side;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        cr;
    logic [31:0] ca;
    logic        vr;
    logic [31:0] va;
    logic        ecg;
    logic        evg;
  } vec_t;

  exp_t        q[$];
  vec_t        tbl[13];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [2:0]  model_v  = 3'b000;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] last_c = 32'd0;
  logic [31:0] last_v = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    if (a == IO_ADDR) return {24'd0, model_v[1:0], model_v, model_v};
    return rom_word(a);
  endfunction

  task automatic check_return();
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (!e.side) begin
        chk("cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        chk("cpu_rdata", cpu_rdata, e.data);
        chk("vid_rvalid idle", {31'd0, vid_rvalid}, 32'd0);
        chk("vid_rdata hold", vid_rdata, last_v);
        last_c = e.data;
      end else begin
        chk("vid_rvalid", {31'd0, vid_rvalid}, 32'd1);
        chk("vid_rdata", vid_rdata, e.data);
        chk("cpu_rvalid idle", {31'd0, cpu_rvalid}, 32'd0);
        chk("cpu_rdata hold", cpu_rdata, last_c);
        last_v = e.data;
      end
    end else begin
      chk("cpu_rvalid none", {31'd0, cpu_rvalid}, 32'd0);
      chk("vid_rvalid none", {31'd0, vid_rvalid}, 32'd0);
    end
  endtask

  // Called at a negedge: drive one cycle, check grant, then check the return next cycle
  task automatic step(input logic cr, input logic [31:0] ca, input logic vr,
                      input logic [31:0] va, input logic ecg, input logic evg);
    exp_t e;
    cpu_req = cr; cpu_addr = ca; vid_req = vr; vid_addr = va;
    #1;
    chk("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, ecg});
    chk("vid_gnt", {31'd0, vid_gnt}, {31'd0, evg});
    if (ecg) begin
      chk("mem_addr cpu", mem_addr, ca);
      e.side = 1'b0; e.data = exp_data(ca);
      q.push_back(e);
      last_addr = ca;
    end else if (evg) begin
      chk("mem_addr vid", mem_addr, va);
      e.side = 1'b1; e.data = exp_data(va);
      q.push_back(e);
      last_addr = va;
    end else begin
      chk("mem_addr hold", mem_addr, last_addr);
    end
    @(negedge clk);
    check_return();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h10, 1'b0, 32'h0,  1'b1, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,  1'b1, 32'h44, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 32'h20, 1'b1, 32'h40, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 32'h20, 1'b1, 32'h40, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 32'h20, 1'b1, 32'h40, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 32'h20, 1'b1, 32'h40, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 32'h20, 1'b1, 32'h40, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 32'h20, 1'b1, 32'h40, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0};
    tbl[9]  = '{1'b1, 32'd255, 1'b0, 32'h0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 32'h0,  1'b1, 32'd252, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 32'd253, 1'b1, 32'h80, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 32'h0,  1'b1, 32'h80, 1'b0, 1'b1};

    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_addr = 32'd0; vid_req = 1'b0; vid_addr = 32'd0;
    switch1 = 1'b0; switch2 = 1'b0; switch3 = 1'b0;
    #12;
    chk("reset cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    chk("reset vid_gnt", {31'd0, vid_gnt}, 32'd0);
    chk("reset cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("reset vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
    chk("reset cpu_rdata", cpu_rdata, 32'd0);
    chk("reset vid_rdata", vid_rdata, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].cr, tbl[i].ca, tbl[i].vr, tbl[i].va, tbl[i].ecg, tbl[i].evg);
    end

    // Switch pattern 101 read through the I/O address
    switch1 = 1'b1; switch2 = 1'b0; switch3 = 1'b1;
    idle(2 + DEB + 2);
    model_v = 3'b101;
    step(1'b1, IO_ADDR, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("io pattern 101", last_c, 32'h6D);

    // Back to 000, then a short glitch on switch2 must be rejected
    switch1 = 1'b0; switch2 = 1'b0; switch3 = 1'b0;
    idle(2 + DEB + 2);
    model_v = 3'b000;
    switch2 = 1'b1;
    idle(5);
    switch2 = 1'b0;
    idle(DEB + 4);
    step(1'b1, IO_ADDR, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("io after glitch", last_c, 32'h00);

    switch2 = 1'b1;
    idle(20);
    model_v = 3'b010;
    step(1'b0, 32'd0, 1'b1, IO_ADDR, 1'b0, 1'b1);
    chk("io pattern 010", last_v, 32'h92);

    // I/O read by video in contention after a CPU grant, then CPU served next
    step(1'b1, 32'h08, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 32'h08, 1'b1, IO_ADDR, 1'b0, 1'b1);
    step(1'b1, 32'h08, 1'b0, 32'd0, 1'b1, 1'b0);

    // Reset right after a grant: pending return is dropped
    cpu_req = 1'b1; cpu_addr = 32'h30; vid_req = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("mid-rst cpu_rdata", cpu_rdata, 32'd0);
    chk("mid-rst vid_rdata", vid_rdata, 32'd0);
    chk("mid-rst mem_addr", mem_addr, 32'd0);
    chk("mid-rst cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    cpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("in-rst cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      chk("in-rst vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
    end
    rst_n = 1'b1;
    q.delete();
    last_addr = 32'd0; last_c = 32'd0; last_v = 32'd0;
    idle(1);
    step(1'b1, 32'h50, 1'b1, 32'h60, 1'b1, 1'b0);
    step(1'b0, 32'h0,  1'b1, 32'h60, 1'b0, 1'b1);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
